ps2_receiver: RTL
=================

// Module: ps2_receiver
// PURPOSE
//  PS/2 keyboard deserializer feeding the iomemory keyboard register (0x4000 data / 0x4004 control).
//  Synchronizes PS2_CLK/PS2_DAT, shifts 11-bit frames (start, 8 data LSB-first, odd parity, stop) and checks them.
//  Holds the last good scancode for the CPU.
//  Tags a byte that follows the 0xF0 prefix as a key release.
// PARAMETERS
//  SYNC_STAGES     2      flops in each input synchronizer (>=2)
//  TIMEOUT_CYCLES  5000   clk cycles without a PS2_CLK falling edge before frame abort (PS2_TIMEOUT_EN only)
// PORTS
//  clk             in   1  system clock; only clock domain
//  rst             in   1  synchronous, active-high reset
//  PS2_CLK         in   1  raw keyboard clock (asynchronous)
//  PS2_DAT         in   1  raw keyboard data (asynchronous)
//  clear           in   1  CPU acknowledge (write to 0x4000); clears key_ready/overrun
//  scancode        out  8  byte of the most recent valid frame
//  scancode_valid  out  1  1-cycle strobe: good frame completed
//  frame_error     out  1  1-cycle strobe: bad start/parity/stop or timeout
//  key_code        out  8  held last non-prefix scancode
//  is_break        out  1  key_code is a release (preceded by 0xF0)
//  key_ready       out  1  sticky: new key_code not yet acknowledged
//  overrun         out  1  sticky: key_code overwritten while key_ready=1
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, shift reg 0, break_pending 0.
//  Input sync: both pins pass through SYNC_STAGES flops with identical delay. Falling edge = prev synced CLK 1, current 0.
//  PS2_CLK must hold each level >=1 clk cycle.
//  FSM (advances only on a falling edge; synced PS2_DAT sampled on that edge):
//   IDLE   : DAT=0 -> DATA, bit_cnt=0; DAT=1 -> stay (spurious edge ignored, no error)
//   DATA   : shift in LSB-first; after 8th bit -> PARITY
//   PARITY : store bit -> STOP
//   STOP   : always -> IDLE; good = (^data ^ parity)==1 && DAT==1
//  Good frame:
//   - scancode/scancode_valid update on the cycle of the stop edge.
//   - Latency from the raw stop-bit falling edge: SYNC_STAGES+1 clk cycles.
//  Bad frame: frame_error pulses once; scancode, key_* and break_pending are unchanged.
//  Prefix handling (on a good frame):
//   - 0xF0: break_pending=1; key_* unchanged.
//   - 0xE0: ignored for key_*; break_pending kept.
//   - any other byte: key_code=byte, is_break=break_pending, break_pending=0, key_ready=1; overrun|=key_ready.
//  clear and a new key in the same cycle: the new key wins, so key_ready=1.
//   Overrun is cleared, then set to the old key_ready value.
//  rst mid-frame: frame discarded, no strobe, FSM to IDLE next cycle.
// CONFIGURATION
//  PS2_TIMEOUT_EN defined:
//   - An idle counter runs whenever FSM!=IDLE and resets on every falling edge.
//   - At TIMEOUT_CYCLES: FSM -> IDLE and frame_error pulses once.
//  Not defined: no counter; a partial frame waits indefinitely.
// STRUCTURE
//  ps2_pkg: typedef enum logic[1:0] {IDLE,DATA,PARITY,STOP} ps2_state_t;
//   localparams PS2_BREAK=8'hF0, PS2_EXT=8'hE0.
//  Sub-module ps2_sync_edge: N-flop synchronizer plus falling-edge detector.
//   Used for PS2_CLK; PS2_DAT uses the same synchronizer without the edge output.
// TESTING
//  1 Bits 0,1,0,1,0,1,0,1,0,1,1 (start..stop), PS2_CLK period 20ns, clk 10ns
//    -> scancode=0x55, one valid strobe, key_code=0x55, key_ready=1, is_break=0.
//  2 Frame 0xD3 with parity 0 -> valid; same frame with parity 1 -> frame_error only, key_code stays 0x55.
//  3 Frame 0xF0 then 0x1C -> key_code=0x1C, is_break=1; following 0x1C -> is_break=0.
//  4 Two keys 0x1C, 0x32 without clear -> key_code=0x32, overrun=1.
//    clear -> key_ready=0, overrun=0. clear on the same cycle as a new key -> key_ready=1.
//  5 rst pulsed after 4 data bits -> no strobes; next full frame 0x29 decodes correctly.
//    Stop bit 0 -> frame_error.
//  6 PS2_TIMEOUT_EN, TIMEOUT_CYCLES=50: stop PS2_CLK mid-frame
//    -> frame_error after 50 cycles; next frame decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types and constants.
//   ps2_state_t   : frame deserializer states
//   PS2_BREAK     : release prefix byte
//   PS2_EXT       : extended-key prefix byte
//   odd_parity_ok : 1 when data plus parity bit hold an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the raw PS/2 clock and data pins through identical flop chains, so both
// arrive with the same delay, and flags a falling edge of the synchronized clock.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   ps2_clk_i raw PS/2 clock (asynchronous)
//   ps2_dat_i raw PS/2 data (asynchronous)
//   dat_o     synchronized data, aligned with the edge flag
//   fall_o    synchronized clock went 1 -> 0 this cycle
module ps2_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic dat_o,
  output logic fall_o
);

  // Bit 0 carries the clock pin, bit 1 the data pin.
  logic [Stages-1:0][1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d[0] = {ps2_dat_i, ps2_clk_i};
    for (int i = 1; i < Stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[Stages-1][0];
  end

  // Reset to the idle-bus level (both lines high) so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dat_o  = sync_q[Stages-1][1];
  assign fall_o = prev_q & ~sync_q[Stages-1][0];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard deserializer for the keyboard register (data / control).
// Shifts 11-bit frames (start, 8 data LSB-first, odd parity, stop), checks them, holds the
// last good scancode and tracks key presses/releases (0xF0 prefix marks a release).
// Optional feature: define PS2_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES clk cycles
// without a PS2_CLK falling edge.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   PS2_CLK/PS2_DAT raw keyboard pins (asynchronous)
//   clear           CPU acknowledge; clears key_ready and overrun
//   scancode        byte of the most recent valid frame
//   scancode_valid  1-cycle strobe per good frame
//   frame_error     1-cycle strobe per bad frame or timeout
//   key_code        last non-prefix scancode
//   is_break        key_code is a release
//   key_ready       sticky: key_code not yet acknowledged
//   overrun         sticky: key_code replaced while key_ready was set
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       clear,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_error,
  output logic [7:0] key_code,
  output logic       is_break,
  output logic       key_ready,
  output logic       overrun
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_receiver: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic ps2_dat_s, ps2_fall;

  ps2_sync_edge #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk_i(PS2_CLK),
    .ps2_dat_i(PS2_DAT),
    .dat_o    (ps2_dat_s),
    .fall_o   (ps2_fall)
  );

  ps2_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [7:0] scancode_q, scancode_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic [7:0] key_code_q, key_code_d;
  logic       is_break_q, is_break_d;
  logic       key_ready_q, key_ready_d;
  logic       overrun_q, overrun_d;
  logic       break_pending_q, break_pending_d;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    parity_d        = parity_q;
    scancode_d      = scancode_q;
    valid_d         = 1'b0;
    error_d         = 1'b0;
    key_code_d      = key_code_q;
    is_break_d      = is_break_q;
    key_ready_d     = key_ready_q;
    overrun_d       = overrun_q;
    break_pending_d = break_pending_q;

    if (clear) begin
      key_ready_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (ps2_fall) begin
      unique case (state_q)
        IDLE: begin
          // A high data bit here is a spurious edge, not a start bit.
          if (!ps2_dat_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {ps2_dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = ps2_dat_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (odd_parity_ok(shift_q, parity_q) && ps2_dat_s) begin
            scancode_d = shift_q;
            valid_d    = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (valid_d) begin
      if (shift_q == PS2_BREAK) begin
        break_pending_d = 1'b1;
      end else if (shift_q != PS2_EXT) begin
        key_code_d      = shift_q;
        is_break_d      = break_pending_q;
        break_pending_d = 1'b0;
        // A same-cycle clear has already zeroed overrun_d; the new key still wins.
        overrun_d       = overrun_d | key_ready_q;
        key_ready_d     = 1'b1;
      end
    end

`ifdef PS2_TIMEOUT_EN
    tmo_d = '0;
    if (state_q != IDLE && !ps2_fall) begin
      if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        error_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 8'h00;
      parity_q        <= 1'b0;
      scancode_q      <= 8'h00;
      valid_q         <= 1'b0;
      error_q         <= 1'b0;
      key_code_q      <= 8'h00;
      is_break_q      <= 1'b0;
      key_ready_q     <= 1'b0;
      overrun_q       <= 1'b0;
      break_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      scancode_q      <= scancode_d;
      valid_q         <= valid_d;
      error_q         <= error_d;
      key_code_q      <= key_code_d;
      is_break_q      <= is_break_d;
      key_ready_q     <= key_ready_d;
      overrun_q       <= overrun_d;
      break_pending_q <= break_pending_d;
    end
  end

`ifdef PS2_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign scancode       = scancode_q;
  assign scancode_valid = valid_q;
  assign frame_error    = error_q;
  assign key_code       = key_code_q;
  assign is_break       = is_break_q;
  assign key_ready      = key_ready_q;
  assign overrun        = overrun_q;

endmodule
